// File: rtl/axi_rd_arbiter_pkg.sv
// Shared cache/AXI read-side definitions: request-type encodings, master IDs
// and the read arbiter state encoding.
package axi_rd_arbiter_pkg;

    localparam logic [2:0] RD_BYTE = 3'b000;
    localparam logic [2:0] RD_HALF = 3'b001;
    localparam logic [2:0] RD_WORD = 3'b010;
    localparam logic [2:0] RD_LINE = 3'b100;

    localparam int ICACHE_ID = 0;
    localparam int DCACHE_ID = 1;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_IDLE = 1'b0;
    localparam arb_state_t ST_WAIT = 1'b1;

    // Single-beat request types always come back with ret_last on the first beat.
    function automatic logic is_single_beat(input logic [2:0] rd_type);
        return rd_type != RD_LINE;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_picker.sv
// Combinational circular-priority picker: scans req_i starting one past
// last_i and returns the first requester as a onehot grant and an index.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(last_i) + off) % N;
            if (!any_o && req_i[IW'(cand)]) begin
                any_o             = 1'b1;
                gnt_o[IW'(cand)]  = 1'b1;
                idx_o             = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing the bridge read channel between cache masters;
// one outstanding read, return beats routed only to the owning master.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 128
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_rd_req,
    input  logic [NUM_MASTERS*3-1:0]          m_rd_type,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_rd_addr,
    output logic [NUM_MASTERS-1:0]            m_rd_rdy,
    output logic [NUM_MASTERS-1:0]            m_ret_valid,
    output logic [NUM_MASTERS-1:0]            m_ret_last,
    output logic [DATA_WIDTH-1:0]             m_ret_data,
    output logic                              rd_req,
    output logic [2:0]                        rd_type,
    output logic [ADDR_WIDTH-1:0]             rd_addr,
    input  logic                              rd_rdy,
    input  logic                              ret_valid,
    input  logic                              ret_last,
    input  logic [DATA_WIDTH-1:0]             ret_data
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;

    logic [NUM_MASTERS-1:0] win_gnt;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;
    logic                   in_idle;
    logic                   in_wait;

    assign in_idle = (state_q == ST_IDLE);
    assign in_wait = (state_q == ST_WAIT);

    rr_picker #(
        .N  (NUM_MASTERS),
        .IW (IDX_W)
    ) u_picker (
        .req_i  (m_rd_req),
        .last_i (last_grant_q),
        .gnt_o  (win_gnt),
        .idx_o  (win_idx),
        .any_o  (win_any)
    );

    // Request forwarding: zero-latency pass-through of the winner in IDLE.
    always_comb begin
        rd_req   = 1'b0;
        rd_type  = '0;
        rd_addr  = '0;
        m_rd_rdy = '0;
        if (in_idle && win_any) begin
            rd_req   = 1'b1;
            m_rd_rdy = win_gnt & {NUM_MASTERS{rd_rdy}};
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (win_gnt[i]) begin
                    rd_type = m_rd_type[i*3 +: 3];
                    rd_addr = m_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
    end

    always_comb begin
        m_ret_valid = '0;
        m_ret_last  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (in_wait && (owner_q == IDX_W'(i))) begin
                m_ret_valid[i] = ret_valid;
                m_ret_last[i]  = ret_last;
            end
        end
    end

    assign m_ret_data = ret_data;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_req && rd_rdy) begin
                    owner_d      = win_idx;
                    last_grant_d = win_idx;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ret_valid && ret_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_grant resets to the highest index so master 0 wins the first tie.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    a_rdy_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(m_rd_rdy));
    a_no_req_in_wait: assert property (@(posedge clk) disable iff (rst) in_wait |-> !rd_req);
    a_no_ret_in_idle: assert property (@(posedge clk) disable iff (rst) in_idle |-> (m_ret_valid == '0));

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed stimulus pushes expected
// grants/beats, a negedge monitor pops and compares whatever the DUT presents.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 128;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NM-1:0]     m_rd_req = '0;
    logic [NM*3-1:0]   m_rd_type = '0;
    logic [NM*AW-1:0]  m_rd_addr = '0;
    logic [NM-1:0]     m_rd_rdy;
    logic [NM-1:0]     m_ret_valid;
    logic [NM-1:0]     m_ret_last;
    logic [DW-1:0]     m_ret_data;
    logic              rd_req;
    logic [2:0]        rd_type;
    logic [AW-1:0]     rd_addr;
    logic              rd_rdy = 1'b0;
    logic              ret_valid = 1'b0;
    logic              ret_last = 1'b0;
    logic [DW-1:0]     ret_data = '0;

    axi_rd_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_rd_req    (m_rd_req),
        .m_rd_type   (m_rd_type),
        .m_rd_addr   (m_rd_addr),
        .m_rd_rdy    (m_rd_rdy),
        .m_ret_valid (m_ret_valid),
        .m_ret_last  (m_ret_last),
        .m_ret_data  (m_ret_data),
        .rd_req      (rd_req),
        .rd_type     (rd_type),
        .rd_addr     (rd_addr),
        .rd_rdy      (rd_rdy),
        .ret_valid   (ret_valid),
        .ret_last    (ret_last),
        .ret_data    (ret_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_grant;
        int          master;
        logic [31:0] addr;
        logic [2:0]  typ;
        bit          last;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_grant(input int m, input logic [31:0] addr, input logic [2:0] typ);
        exp_t x;
        x.is_grant = 1'b1; x.master = m; x.addr = addr; x.typ = typ; x.last = 1'b0; x.data = '0;
        exp_q.push_back(x);
    endtask

    task automatic push_beat(input int m, input bit last, input logic [127:0] data);
        exp_t x;
        x.is_grant = 1'b0; x.master = m; x.addr = '0; x.typ = '0; x.last = last; x.data = data;
        exp_q.push_back(x);
    endtask

    // Monitor: every grant or return beat the DUT shows must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (|m_rd_rdy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_grant: got m_rd_rdy=%b expected none", m_rd_rdy);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_grant) begin
                        n_fail++;
                        $display("FAIL event_kind: got grant m_rd_rdy=%b expected beat for m%0d", m_rd_rdy, e.master);
                    end else begin
                        check("grant_rdy", 128'(m_rd_rdy), 128'(2'b01 << e.master));
                        check("grant_req", 128'(rd_req), 128'(1));
                        check("grant_addr", 128'(rd_addr), 128'(e.addr));
                        check("grant_type", 128'(rd_type), 128'(e.typ));
                    end
                end
            end
            if (|m_ret_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got m_ret_valid=%b expected none", m_ret_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_grant) begin
                        n_fail++;
                        $display("FAIL event_kind: got beat m_ret_valid=%b expected grant for m%0d", m_ret_valid, e.master);
                    end else begin
                        check("beat_valid", 128'(m_ret_valid), 128'(2'b01 << e.master));
                        check("beat_last", 128'(m_ret_last), 128'(e.last ? (2'b01 << e.master) : 2'b00));
                        check("beat_data", m_ret_data, e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int m, input logic [2:0] typ, input logic [31:0] addr);
        m_rd_req[m]         = 1'b1;
        m_rd_type[m*3 +: 3] = typ;
        m_rd_addr[m*AW +: AW] = addr;
    endtask

    task automatic accept(input int m, output int waited);
        waited = 0;
        settle();
        while (!m_rd_rdy[m] && waited < 20) begin
            tick();
            waited++;
            settle();
        end
        if (!m_rd_rdy[m]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout_m%0d: got no m_rd_rdy after %0d cycles expected accept", m, waited);
        end
        tick();
        m_rd_req[m] = 1'b0;
    endtask

    task automatic beat(input bit last, input logic [127:0] data);
        ret_valid = 1'b1;
        ret_last  = last;
        ret_data  = data;
        tick();
        ret_valid = 1'b0;
        ret_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_rd_req = '0;
        rd_rdy = 1'b0;
        ret_valid = 1'b0;
        ret_last = 1'b0;
        tick();
        tick();
        settle();
        check("rst_rd_req", 128'(rd_req), 128'(0));
        check("rst_rd_type", 128'(rd_type), 128'(0));
        check("rst_rd_addr", 128'(rd_addr), 128'(0));
        check("rst_m_rd_rdy", 128'(m_rd_rdy), 128'(0));
        check("rst_m_ret_valid", 128'(m_ret_valid), 128'(0));
        check("rst_m_ret_last", 128'(m_ret_last), 128'(0));
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "bench timeout");
    end

    initial begin
        int w;
        logic [127:0] d;

        // Single request from dcache.
        do_reset();
        rd_rdy = 1'b1;
        push_grant(DCACHE_ID, 32'h1C00_0014, RD_WORD);
        set_req(DCACHE_ID, RD_WORD, 32'h1C00_0014);
        accept(DCACHE_ID, w);
        settle();
        check("single_wait_rd_req", 128'(rd_req), 128'(0));
        d = {4{32'hA5A5_0001}};
        push_beat(DCACHE_ID, 1'b1, d);
        beat(1'b1, d);

        // Simultaneous requests after reset: 0, 1, 0.
        do_reset();
        rd_rdy = 1'b1;
        push_grant(0, 32'h0000_1000, RD_WORD);
        push_beat(0, 1'b1, {4{32'h1111_0000}});
        push_grant(1, 32'h8000_2002, RD_HALF);
        push_beat(1, 1'b1, {4{32'h2222_0000}});
        push_grant(0, 32'h0000_3003, RD_BYTE);
        push_beat(0, 1'b1, {4{32'h3333_0000}});
        set_req(0, RD_WORD, 32'h0000_1000);
        set_req(1, RD_HALF, 32'h8000_2002);
        accept(0, w);
        set_req(0, RD_BYTE, 32'h0000_3003);
        settle();
        check("holdoff_m_rd_rdy", 128'(m_rd_rdy), 128'(0));
        check("holdoff_rd_req", 128'(rd_req), 128'(0));
        beat(1'b1, {4{32'h1111_0000}});
        settle();
        check("bubble_rd_req", 128'(rd_req), 128'(1));
        check("bubble_rd_addr", 128'(rd_addr), 128'(32'h8000_2002));
        accept(1, w);
        set_req(1, RD_WORD, 32'h8000_4000);
        beat(1'b1, {4{32'h2222_0000}});
        accept(0, w);
        m_rd_req[1] = 1'b0;
        beat(1'b1, {4{32'h3333_0000}});

        // Backpressure: held for 5 cycles, accepted in the 6th.
        rd_rdy = 1'b0;
        set_req(0, RD_WORD, 32'h0000_BEE0);
        for (int c = 0; c < 5; c++) begin
            settle();
            check("bp_rd_req", 128'(rd_req), 128'(1));
            check("bp_rd_addr", 128'(rd_addr), 128'(32'h0000_BEE0));
            check("bp_m_rd_rdy", 128'(m_rd_rdy), 128'(0));
            tick();
        end
        push_grant(0, 32'h0000_BEE0, RD_WORD);
        rd_rdy = 1'b1;
        accept(0, w);
        check("bp_accept_delay", 128'(w), 128'(0));
        push_beat(0, 1'b1, {4{32'h4444_0000}});
        beat(1'b1, {4{32'h4444_0000}});

        // Four-beat line for icache while dcache waits.
        push_grant(0, 32'h0000_4000, RD_LINE);
        set_req(0, RD_LINE, 32'h0000_4000);
        accept(0, w);
        set_req(1, RD_WORD, 32'h9000_0008);
        for (int b = 0; b < 4; b++) begin
            d = {96'h0, 32'hC0DE_0000 + 32'(b)};
            push_beat(0, (b == 3), d);
            ret_valid = 1'b1;
            ret_last  = (b == 3);
            ret_data  = d;
            settle();
            check("line_m1_rdy", 128'(m_rd_rdy[1]), 128'(0));
            tick();
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        push_grant(1, 32'h9000_0008, RD_WORD);
        accept(1, w);
        push_beat(1, 1'b1, {4{32'h5555_0000}});
        beat(1'b1, {4{32'h5555_0000}});

        // Stray beat in IDLE.
        ret_valid = 1'b1;
        ret_last  = 1'b1;
        ret_data  = {4{32'hDEAD_BEEF}};
        settle();
        check("stray_valid", 128'(m_ret_valid), 128'(0));
        check("stray_last", 128'(m_ret_last), 128'(0));
        tick();
        ret_valid = 1'b0;
        ret_last  = 1'b0;

        // Reset in the middle of a line return.
        push_grant(0, 32'h0000_7000, RD_LINE);
        set_req(0, RD_LINE, 32'h0000_7000);
        accept(0, w);
        push_beat(0, 1'b0, {4{32'h6666_0001}});
        beat(1'b0, {4{32'h6666_0001}});
        push_beat(0, 1'b0, {4{32'h6666_0002}});
        beat(1'b0, {4{32'h6666_0002}});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("midrst_m_ret_valid", 128'(m_ret_valid), 128'(0));
        check("midrst_rd_req", 128'(rd_req), 128'(0));
        for (int b = 0; b < 2; b++) begin
            ret_valid = 1'b1;
            ret_last  = (b == 1);
            ret_data  = {4{32'h6666_0003 + 32'(b)}};
            settle();
            check("aborted_beat_valid", 128'(m_ret_valid), 128'(0));
            tick();
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        push_grant(1, 32'h9000_0100, RD_WORD);
        set_req(1, RD_WORD, 32'h9000_0100);
        accept(1, w);
        push_beat(1, 1'b1, {4{32'h7777_0000}});
        beat(1'b1, {4{32'h7777_0000}});

        tick();
        tick();
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single cache-side read channel of the AXI bridge between NUM_MASTERS cache requesters: master 0 = icache, master 1 = dcache.
- Round-robin arbitration with one outstanding read transaction at a time.
- Routes return beats only to the granted master.
- The dcache write channel does not pass through this block; it connects to the bridge directly.

Parameters:
- NUM_MASTERS, 2, number of read requesters.
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 128, return data width (one beat).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- m_rd_req  in  NUM_MASTERS  per-master read request; held with addr/type stable until accepted.
- m_rd_type  in  NUM_MASTERS*3  per-master request type (3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 line); master i uses slice [i*3+:3].
- m_rd_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master start address; master i uses slice [i*ADDR_WIDTH+:ADDR_WIDTH].
- m_rd_rdy  out  NUM_MASTERS  per-master accept strobe; at most one bit high.
- m_ret_valid  out  NUM_MASTERS  per-master return-beat valid.
- m_ret_last  out  NUM_MASTERS  per-master last-beat flag.
- m_ret_data  out  DATA_WIDTH  return data, broadcast; qualified by m_ret_valid.
- rd_req  out  1  bridge read request.
- rd_type  out  3  bridge request type.
- rd_addr  out  ADDR_WIDTH  bridge start address.
- rd_rdy  in  1  bridge accepts the request this cycle.
- ret_valid  in  1  bridge return beat valid.
- ret_last  in  1  bridge last beat.
- ret_data  in  DATA_WIDTH  bridge return data.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset state: state = IDLE; owner = 0; last_grant = NUM_MASTERS-1, so master 0 wins the first tie.
- Outputs after reset: rd_req, rd_type, rd_addr, m_rd_rdy, m_ret_valid and m_ret_last are all 0. m_ret_data follows ret_data combinationally at all times.
- FSM states: IDLE, WAIT.
- IDLE, winner selection: winner = first index with m_rd_req set, scanning circularly from last_grant+1. The selection is combinational.
- IDLE, forwarding: if any request is pending, drive rd_req=1, rd_type/rd_addr = winner's slices, and m_rd_rdy[winner] = rd_rdy. Latency from request to bridge is 0 cycles.
- IDLE, acceptance: on rd_req && rd_rdy, set owner <= winner and last_grant <= winner, then go to WAIT. Otherwise stay in IDLE, and winner may change next cycle.
- Request rules: m_rd_req must not depend combinationally on m_rd_rdy. A master may drop its request before acceptance.
- WAIT: rd_req=0 and m_rd_rdy=0. m_ret_valid[owner] = ret_valid and m_ret_last[owner] = ret_last; all other bits are 0.
- WAIT exit: on ret_valid && ret_last, go to IDLE. A new request is accepted no earlier than the next cycle (1-cycle bubble).
- Word/byte/half requests return a single beat with ret_last=1. Line requests may return 1 or more beats; the arbiter only watches ret_last.
- Stray ret_valid in IDLE: dropped, no master sees it.
- Mid-transaction requests: requests arriving in WAIT are held off (m_rd_rdy=0) and considered on return to IDLE.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1. No master waits more than NUM_MASTERS-1 transactions.
- Reset during WAIT: returns to IDLE next cycle. Return beats for the aborted transaction are dropped; the bridge is reset by the same rst.
- rst has priority over all transitions.
- Assertions: $onehot0(m_rd_rdy); rd_req is never high in WAIT; no m_ret_valid bit is high in IDLE.

Decomposition:
- Shared cache/AXI package holds:
  - rd_type encodings: RD_BYTE=3'b000, RD_HALF=3'b001, RD_WORD=3'b010, RD_LINE=3'b100.
  - Master index constants: ICACHE_ID=0, DCACHE_ID=1.
  - The arbiter state enum.
- One sub-module: rr_picker (pure combinational circular priority picker: req vector + last_grant -> onehot grant + index). Reusable for the future write-channel arbiter.

Test Plan:
- Single request: only m1 requests word at 0x1C00_0014, rd_rdy=1, then bridge returns 1 beat with ret_last=1 -> rd_addr=0x1C00_0014, rd_type=3'b010, m_rd_rdy=2'b10. Then m_ret_valid=2'b10 with data=ret_data, back in IDLE next cycle.
- Simultaneous requests after reset: both masters request -> master 0 granted first. After its ret_last, master 1 granted with a 1-cycle gap. A third round gives master 0 again.
- Backpressure: m0 requests, rd_rdy=0 for 5 cycles -> rd_req held high and rd_addr stable, m_rd_rdy=0 throughout. Accepted in cycle 6.
- Multi-beat line: m0 line read, 4 beats, ret_last on the 4th -> m_ret_valid[0] pulses 4 times, m_ret_last[0] only on beat 4. m1 requesting meanwhile sees m_rd_rdy[1]=0 until IDLE.
- Stray beat: ret_valid=1 in IDLE -> m_ret_valid=0.
- Reset mid-WAIT: rst pulsed after 2 of 4 beats -> outputs 0 next cycle. Subsequent beats are not routed. A fresh m1 request is granted first, since last_grant resets to 1 and master 0 is not requesting.
